// File: rtl/sha256_padder_if.sv
// Stream-in / block-out bundle between the message source, the padder and the SHA-256 core.
// The slave side is the padder itself; the master side is whatever surrounds it.
interface sha256_padder_if;
  logic         in_valid;
  logic [31:0]  in_data;
  logic         in_last;
  logic [1:0]   in_bytes;
  logic         in_ready;
  logic [511:0] core_block;
  logic         core_init;
  logic         core_next;
  logic         core_mode;
  logic         core_ready;
  logic         done;
  logic         busy;

  modport master (
    output in_valid, in_data, in_last, in_bytes, core_ready,
    input  in_ready, core_block, core_init, core_next, core_mode, done, busy
  );

  modport slave (
    input  in_valid, in_data, in_last, in_bytes, core_ready,
    output in_ready, core_block, core_init, core_next, core_mode, done, busy
  );
endinterface

// File: rtl/sha256_padder.sv
// Collects big-endian message words into 512-bit blocks, appends SHA-256 padding and the
// 64-bit bit length, and hands each block to the core with init/next sequencing.
module sha256_padder #(
  parameter bit MODE_DEFAULT = 1'b1
) (
  input  logic clk,
  input  logic reset,
  sha256_padder_if.slave bus
);

  typedef enum logic [2:0] {IDLE, FILL, PAD, LEN, SEND, WAIT} state_t;

  state_t      state;
  logic [31:0] blk [16];
  logic [3:0]  word_idx;
  logic [63:0] bit_len;
  logic        first;
  logic        final_blk;
  logic        extra;
  logic        pad_done;
  logic        wait_first;
  logic        ready_q;
  logic        busy_q;
  logic        init_q;
  logic        next_q;
  logic        done_q;

  logic        accept;
  logic [63:0] last_bits;

  assign accept    = bus.in_valid && ready_q;
  assign last_bits = (bus.in_bytes == 2'd0) ? 64'd32 : {59'd0, bus.in_bytes, 3'd0};

  // Keep the valid leading bytes of the final word and drop the 0x80 marker right behind them.
  function automatic logic [31:0] pad_last(input logic [31:0] d, input logic [1:0] nb);
    case (nb)
      2'd1:    return {d[31:24], 8'h80, 16'h0000};
      2'd2:    return {d[31:16], 8'h80, 8'h00};
      2'd3:    return {d[31:8], 8'h80};
      default: return d;
    endcase
  endfunction

  assign bus.in_ready  = ready_q;
  assign bus.busy      = busy_q;
  assign bus.core_init = init_q;
  assign bus.core_next = next_q;
  assign bus.done      = done_q;
  assign bus.core_mode = MODE_DEFAULT;

  for (genvar g = 0; g < 16; g++) begin : g_block
    assign bus.core_block[511-32*g -: 32] = blk[g];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      word_idx   <= 4'd0;
      bit_len    <= 64'd0;
      first      <= 1'b1;
      final_blk  <= 1'b0;
      extra      <= 1'b0;
      pad_done   <= 1'b0;
      wait_first <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      init_q     <= 1'b0;
      next_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < 16; i++) blk[i] <= 32'd0;
    end else begin
      init_q <= 1'b0;
      next_q <= 1'b0;
      done_q <= 1'b0;
      case (state)
        IDLE, FILL: begin
          ready_q <= 1'b1;
          if (accept) begin
            busy_q   <= 1'b1;
            word_idx <= word_idx + 4'd1;
            if (!bus.in_last) begin
              blk[word_idx] <= bus.in_data;
              bit_len       <= bit_len + 64'd32;
              if (word_idx == 4'd15) begin
                pad_done <= 1'b0;
                ready_q  <= 1'b0;
                state    <= SEND;
              end else begin
                state <= FILL;
              end
            end else begin
              blk[word_idx] <= pad_last(bus.in_data, bus.in_bytes);
              bit_len       <= bit_len + last_bits;
              pad_done      <= (bus.in_bytes != 2'd0);
              ready_q       <= 1'b0;
              // A final word landing in slot 15 fills the block: padding moves to an extra block.
              if (word_idx == 4'd15) begin
                extra <= 1'b1;
                state <= SEND;
              end else begin
                state <= PAD;
              end
            end
          end
        end
        PAD: begin
          if (word_idx == 4'd14 && pad_done) begin
            state <= LEN;
          end else begin
            blk[word_idx] <= pad_done ? 32'd0 : 32'h8000_0000;
            pad_done      <= 1'b1;
            word_idx      <= word_idx + 4'd1;
            if (word_idx == 4'd13) begin
              state <= LEN;
            end else if (word_idx == 4'd15) begin
              extra <= 1'b1;
              state <= SEND;
            end
          end
        end
        LEN: begin
          blk[14]   <= bit_len[63:32];
          blk[15]   <= bit_len[31:0];
          final_blk <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (bus.core_ready) begin
            if (first) init_q <= 1'b1;
            else       next_q <= 1'b1;
            first      <= 1'b0;
            word_idx   <= 4'd0;
            wait_first <= 1'b1;
            state      <= WAIT;
          end
        end
        WAIT: begin
          // The core still shows ready in the cycle right after the pulse, so skip that cycle.
          if (wait_first) begin
            wait_first <= 1'b0;
          end else if (bus.core_ready) begin
            if (final_blk) begin
              done_q    <= 1'b1;
              bit_len   <= 64'd0;
              first     <= 1'b1;
              final_blk <= 1'b0;
              extra     <= 1'b0;
              busy_q    <= 1'b0;
              ready_q   <= 1'b1;
              state     <= IDLE;
              for (int i = 0; i < 16; i++) blk[i] <= 32'd0;
            end else if (extra) begin
              extra <= 1'b0;
              state <= PAD;
            end else begin
              ready_q <= 1'b1;
              state   <= FILL;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_padder.sv
// Self-checking bench: random messages are padded by a byte-level reference model and the
// blocks the padder presents to a modelled SHA-256 core are compared against it.
module tb_sha256_padder;

  logic clk = 1'b0;
  logic reset;

  sha256_padder_if bus ();

  sha256_padder #(.MODE_DEFAULT(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0]   msg_bytes [$];
  logic [511:0] exp_blocks [$];

  task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic reportTimeout(input string tag);
    checks++;
    failures++;
    $display("[TB] FAIL %s observed=timeout expected=event", tag);
  endtask

  // Reference padding straight from the rules: bytes, 0x80, zeros to 56 mod 64, 64-bit bit length.
  task automatic buildModel();
    logic [7:0]   p [$];
    logic [63:0]  len;
    logic [511:0] b;
    p = msg_bytes;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    len = 64'(msg_bytes.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(len[8*i +: 8]);
    exp_blocks.delete();
    for (int k = 0; k < p.size() / 64; k++) begin
      b = '0;
      for (int j = 0; j < 64; j++) b[511-8*j -: 8] = p[64*k + j];
      exp_blocks.push_back(b);
    end
  endtask

  task automatic driveWords();
    int          n;
    int          nwords;
    int          t;
    logic [31:0] data;
    int          idx;
    n      = msg_bytes.size();
    nwords = (n + 3) / 4;
    @(negedge clk);
    for (int w = 0; w < nwords; w++) begin
      for (int b = 0; b < 4; b++) begin
        idx = 4*w + b;
        data[31-8*b -: 8] = (idx < n) ? msg_bytes[idx] : 8'($urandom);
      end
      bus.in_data  = data;
      bus.in_last  = (w == nwords - 1);
      bus.in_bytes = (w == nwords - 1) ? 2'(n % 4) : 2'($urandom);
      bus.in_valid = 1'b1;
      t = 0;
      while (!bus.in_ready && t < 5000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 5000) begin
        reportTimeout("in_ready_wait");
        break;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic coreModel(input int hold, input bit abort);
    int           k;
    int           t;
    bit           fin;
    logic [511:0] held;
    k   = 0;
    t   = 0;
    fin = 1'b0;
    while (!fin) begin
      @(negedge clk);
      t++;
      if (t > 20000) begin
        reportTimeout("done_wait");
        fin = 1'b1;
      end else if (bus.core_init || bus.core_next) begin
        checkOutput("pulse_kind", {bus.core_init, bus.core_next}, (k == 0) ? 2'b10 : 2'b01);
        if (k < exp_blocks.size()) checkOutput("block", bus.core_block, exp_blocks[k]);
        else                       checkOutput("surplus_block", k, exp_blocks.size());
        held = bus.core_block;
        k++;
        bus.core_ready = 1'b0;
        if (abort) begin
          repeat (2) @(negedge clk);
          reset = 1'b1;
          @(negedge clk);
          checkOutput("reset_outputs",
                      {bus.in_ready, bus.busy, bus.core_init, bus.core_next, bus.done, bus.core_mode},
                      6'b000001);
          checkOutput("reset_block", bus.core_block, '0);
          reset          = 1'b0;
          bus.core_ready = 1'b1;
          fin            = 1'b1;
        end else begin
          for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput("hold_in_ready", bus.in_ready, 1'b0);
            checkOutput("hold_block", bus.core_block, held);
            checkOutput("hold_pulses", {bus.core_init, bus.core_next, bus.done}, 3'b000);
          end
          bus.core_ready = 1'b1;
        end
      end else if (bus.done) begin
        checkOutput("blocks_before_done", k, exp_blocks.size());
        @(negedge clk);
        checkOutput("done_width_busy", {bus.done, bus.busy}, 2'b00);
        fin = 1'b1;
      end
    end
  endtask

  task automatic applyStimulus(input int len, input int hold, input bit abort, input bit abc);
    msg_bytes.delete();
    if (abc) begin
      msg_bytes.push_back(8'h61);
      msg_bytes.push_back(8'h62);
      msg_bytes.push_back(8'h63);
    end else begin
      for (int i = 0; i < len; i++) msg_bytes.push_back(8'($urandom));
    end
    buildModel();
    bus.core_ready = 1'b1;
    fork
      driveWords();
      coreModel(hold, abort);
    join
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 32'd0;
    bus.in_last  = 1'b0;
    bus.in_bytes = 2'd0;
    bus.core_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_state",
                {bus.in_ready, bus.busy, bus.core_init, bus.core_next, bus.done, bus.core_mode},
                6'b000001);
    checkOutput("reset_block", bus.core_block, '0);
    reset = 1'b0;
    @(negedge clk);

    applyStimulus(3, 4, 1'b0, 1'b1);
    applyStimulus(55, 3, 1'b0, 1'b0);
    applyStimulus(56, 3, 1'b0, 1'b0);
    applyStimulus(64, 70, 1'b0, 1'b0);
    applyStimulus(60, 2, 1'b0, 1'b0);
    applyStimulus(61, 1, 1'b0, 1'b0);
    applyStimulus(63, 2, 1'b0, 1'b0);
    applyStimulus(57, 1, 1'b0, 1'b0);
    applyStimulus(56, 5, 1'b1, 1'b0);
    applyStimulus(3, 2, 1'b0, 1'b1);
    for (int r = 0; r < 6; r++) begin
      applyStimulus(int'($urandom_range(1, 200)), int'($urandom_range(1, 8)), 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sha256_padder.md
Name: sha256_padder

Overview:
- Upstream stage of the SHA-256 wrapper/core.
- Accepts a message as a stream of big-endian 32-bit words and builds 512-bit blocks with FIPS 180-4 padding: a 0x80 byte, zero fill, and the 64-bit message bit length.
- Presents each block to the core and sequences init (first block) and next (later blocks), using the core's ready handshake.
- Raises a done pulse when the final block has been absorbed.

Parameters:
- MODE_DEFAULT, 1, value driven on core_mode (1 = SHA-256, 0 = SHA-224).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word present.
- in_data  in  32  message word; byte [31:24] comes first.
- in_last  in  1  word is the final word of the message.
- in_bytes  in  2  valid bytes in the last word, left-aligned (0 = 4 bytes, 1..3 = that many); ignored unless in_last.
- in_ready  out  1  padder can accept a word this cycle; a transfer occurs when in_valid && in_ready.
- core_block  out  512  block to core; word 0 at [511:480].
- core_init  out  1  one-cycle pulse for the first block.
- core_next  out  1  one-cycle pulse for each later block.
- core_mode  out  1  constant MODE_DEFAULT.
- core_ready  in  1  core idle / ready.
- done  out  1  one-cycle pulse when the core returns ready after the final block.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: all outputs 0, except core_mode = MODE_DEFAULT. Block buffer zeroed, word_idx = 0, bit_len = 0, first = 1, state IDLE. Reset mid-message abandons the message; no pulse is emitted.
- Storage:
  - 16x32 block buffer; word_idx is 4 bits.
  - bit_len is a 64-bit counter, +32 per full word; the last word adds 8*in_bytes (32 if in_bytes = 0).
  - Wrap of bit_len past 2^64 is not detected.
- FSM states: IDLE, FILL, PAD, LEN, SEND, WAIT.
- in_ready = 1 only in IDLE and FILL.
- IDLE -> FILL: on the first accepted word; that word is handled exactly as in FILL.
- FILL, accepted non-last word:
  - Store at word_idx, then word_idx++.
  - If word_idx was 15: next state SEND, with pad_pending = 0 (no padding yet).
- FILL, accepted last word:
  - Bytes beyond in_bytes are forced to 0.
  - If in_bytes != 0: 0x80 is written into the first invalid byte of the same word, and pad_done = 1.
  - Then word_idx++ and go to PAD.
- PAD:
  - If pad_done = 0: write 0x80000000 at word_idx, word_idx++, pad_done = 1.
  - Zero-fill words up to index 13, one word per cycle.
  - When word_idx reaches 14: go to LEN.
  - If word_idx > 14 once padding has been placed: zero the remainder, mark extra = 1, and go to SEND; the next block restarts PAD at word 0 with pad_done = 1.
  - word_idx wrapping to 0 in PAD (block full) also goes to SEND with extra = 1.
- LEN: word14 = bit_len[63:32], word15 = bit_len[31:0]; set final = 1; go to SEND.
- SEND:
  - Wait for core_ready = 1, then pulse core_init if first = 1, else core_next, for exactly one cycle.
  - On the pulse: clear first, word_idx = 0, go to WAIT.
  - core_block holds the buffer contents and stays stable from SEND entry until WAIT exits.
- WAIT:
  - Ignore core_ready in the first WAIT cycle (the core drops ready one cycle after the pulse).
  - Afterwards, on core_ready = 1, pick the next state:
    - final: pulse done, clear the buffer, bit_len, first and final, and go to IDLE.
    - extra: go to PAD.
    - otherwise: go to FILL.
- A 64-byte-multiple message whose last word fills word 15 goes FILL -> SEND; the following block then starts in PAD with pad_done = 0.
- An in_valid word arriving while in_ready = 0 is held by the source (standard valid/ready rule); it is not lost.
- Zero-length messages are unsupported; every message must contain at least one word.
- Only one of core_init and core_next is ever high, and each is high for one cycle per block.

Test Plan:
- "abc": single word 0x61626300, in_last = 1, in_bytes = 3 -> one core_init; word0 = 0x61626380, words 1-14 = 0, word15 = 0x00000018; done after core ready returns; no core_next.
- 55-byte message (14 words, last with in_bytes = 3) -> single block; byte 55 = 0x80; word15 = 0x000001B8; exactly one pulse.
- 56-byte message (14 full words) -> block 1: word14 = 0x80000000, word15 = 0 with core_init; block 2: words 0-13 = 0, word15 = 0x000001C0 with core_next; then done.
- 64-byte message (16 words) -> block 1 = the data with core_init; block 2: word0 = 0x80000000, word15 = 0x00000200 with core_next.
- Core model holds core_ready low for 70 cycles after each pulse -> in_ready stays 0 and core_block stays constant during that time; no pulse is repeated.
- Assert reset during WAIT of block 1 of a 2-block message -> all outputs 0 on the next cycle; a following "abc" message produces the correct single-block result starting with core_init.
